// File: rtl/hamming74_pkg.sv
// rtl/hamming74_pkg.sv - shared Hamming(7,4) codeword layout, frame constants and tx state encoding
// Purpose: single source of truth for bit positions and frame geometry used by
//          the serial Hamming(7,4) encoder and decoder.
// Contents: data/parity bit positions, FRAME_SLOTS, LAST_DATA_SLOT, tx_state_e.
package hamming74_pkg;

  // Codeword slot positions (cw[i] is transmitted in slot i).
  localparam int D0_POS = 0;
  localparam int D1_POS = 1;
  localparam int D2_POS = 2;
  localparam int D3_POS = 4;
  localparam int P0_POS = 3;  // d2 ^ d1 ^ d0
  localparam int P1_POS = 5;  // d3 ^ d1 ^ d0
  localparam int P2_POS = 6;  // d3 ^ d2 ^ d0

  // Seven codeword slots plus one gap slot: matches the decoder's 3-bit slot counter.
  localparam int FRAME_SLOTS    = 8;
  localparam int LAST_DATA_SLOT = 6;
  localparam int SLOT_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/hamming74_parity_gen.sv
// rtl/hamming74_parity_gen.sv - combinational Hamming(7,4) codeword builder
// Purpose: maps a 4-bit nibble {d3,d2,d1,d0} onto the 7-bit codeword layout.
// Ports:
//   nibble   in  4  data nibble {d3,d2,d1,d0}
//   codeword out 7  codeword, bit i is sent in slot i
module hamming74_parity_gen
  import hamming74_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] codeword
);

  always_comb begin
    codeword         = '0;
    codeword[D0_POS] = nibble[0];
    codeword[D1_POS] = nibble[1];
    codeword[D2_POS] = nibble[2];
    codeword[D3_POS] = nibble[3];
    codeword[P0_POS] = nibble[2] ^ nibble[1] ^ nibble[0];
    codeword[P1_POS] = nibble[3] ^ nibble[1] ^ nibble[0];
    codeword[P2_POS] = nibble[3] ^ nibble[2] ^ nibble[0];
  end

endmodule

// File: rtl/hamming74_encoder_tx.sv
// rtl/hamming74_encoder_tx.sv - serial Hamming(7,4) encoder/transmitter, 8-slot frames
// Purpose: accepts nibbles on a valid/ready handshake, sends each 7-bit codeword
//          LSB first one bit per enabled clock, followed by one gap slot.
// Ports:
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   ena         in   1  clock enable for frame advance and handshake
//   data_in     in   4  nibble {d3,d2,d1,d0}
//   data_valid  in   1  data_in is presented
//   data_ready  out  1  a nibble can be accepted this cycle
//   encode_out  out  1  serial codeword bit (IDLE_LEVEL when idle / in gap)
//   bit_valid   out  1  encode_out carries a codeword bit (slots 0-6)
//   frame_start out  1  slot 0 of a frame
//   busy        out  1  frame in progress or nibble pending
module hamming74_encoder_tx
  import hamming74_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       encode_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       busy
);

  tx_state_e          state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [6:0]         cw_q, cw_d;
  logic               pend_full_q, pend_full_d;
  logic [3:0]         pend_q, pend_d;

  logic               accept;
  logic [3:0]         enc_src;
  logic [6:0]         enc_cw;

  // rst_n gates ready so it reads 0 while held in reset and 1 straight after.
  assign data_ready = rst_n & ~pend_full_q;
  assign accept     = ena & data_valid & data_ready;

  // The pending nibble has priority; otherwise a live nibble bypasses the buffer.
  // In IDLE the pending register is always empty, so this picks data_in there.
  assign enc_src = pend_full_q ? pend_q : data_in;

  hamming74_parity_gen u_parity_gen (
    .nibble   (enc_src),
    .codeword (enc_cw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      cw_q        <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cw_q        <= cw_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cw_d        = cw_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;

    if (ena) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cw_d    = enc_cw;
            slot_d  = '0;
            state_d = SEND;
          end
        end

        SEND: begin
          if (accept) begin
            pend_full_d = 1'b1;
            pend_d      = data_in;
          end
          // Stepping past the last data slot lands on the gap slot (7).
          slot_d = slot_q + 1'b1;
          if (slot_q == SLOT_W'(LAST_DATA_SLOT)) begin
            state_d = GAP;
          end
        end

        GAP: begin
          if (pend_full_q) begin
            // Load and refill in one cycle: the buffer is vacated here and
            // reoccupied only if a new nibble is accepted at the same edge.
            cw_d        = enc_cw;
            slot_d      = '0;
            state_d     = SEND;
            pend_full_d = accept;
            if (accept) begin
              pend_d = data_in;
            end
          end else if (accept) begin
            // Nibble arriving in the gap with nothing pending starts the next
            // frame directly instead of stranding in the buffer.
            cw_d    = enc_cw;
            slot_d  = '0;
            state_d = SEND;
          end else begin
            slot_d  = '0;
            state_d = IDLE;
          end
        end

        default: begin
          slot_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bit_valid   = (state_q == SEND);
  assign encode_out  = bit_valid ? cw_q[slot_q] : IDLE_LEVEL;
  assign frame_start = bit_valid & (slot_q == '0);
  assign busy        = (state_q != IDLE) | pend_full_q;

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// tb/tb_hamming74_encoder_tx.sv - self-checking bench for hamming74_encoder_tx
module tb_hamming74_encoder_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       encode_out;
  logic       bit_valid;
  logic       frame_start;
  logic       busy;

  logic [3:0] pg_in;
  logic [6:0] pg_out;

  always #5 clk = ~clk;

  hamming74_encoder_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .encode_out  (encode_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  hamming74_parity_gen u_pg (
    .nibble   (pg_in),
    .codeword (pg_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: frame position -1 = idle, 0..6 data slots, 7 gap.
  int          m_pos;
  int unsigned m_cw;
  int          m_q[$];
  bit          m_acc;

  // Frame collector / loopback decoder.
  logic [6:0]  fr;
  int          fc;
  int          dq[$];

  typedef struct {
    logic [3:0] nib;
    logic [6:0] cw;
  } vec_t;
  vec_t vecs[7];

  function automatic int unsigned ref_cw(input int n);
    int d0 = n % 2;
    int d1 = (n / 2) % 2;
    int d2 = (n / 4) % 2;
    int d3 = (n / 8) % 2;
    return d0 + d1 * 2 + d2 * 4 + ((d0 + d1 + d2) % 2) * 8 + d3 * 16
         + ((d0 + d1 + d3) % 2) * 32 + ((d0 + d2 + d3) % 2) * 64;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return (rst_n === 1'b1) && (m_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_pos = -1;
    m_cw  = 0;
    m_q.delete();
  endtask

  task automatic model_clock();
    m_acc = 1'b0;
    if (rst_n !== 1'b1 || ena !== 1'b1) return;
    m_acc = data_valid && m_ready();
    if (m_pos < 0) begin
      if (m_acc) begin
        m_cw  = ref_cw(int'(data_in));
        m_pos = 0;
      end
    end else if (m_pos < 7) begin
      m_pos++;
      if (m_acc) m_q.push_back(int'(data_in));
    end else begin
      if (m_q.size() > 0) begin
        m_cw  = ref_cw(m_q.pop_front());
        m_pos = 0;
        if (m_acc) m_q.push_back(int'(data_in));
      end else if (m_acc) begin
        m_cw  = ref_cw(int'(data_in));
        m_pos = 0;
      end else begin
        m_pos = -1;
      end
    end
  endtask

  task automatic compare_model(input string name);
    logic [4:0] exp;
    logic       bv;
    bv  = (m_pos >= 0) && (m_pos <= 6);
    exp = {m_ready(),
           bv ? logic'((m_cw >> m_pos) & 1) : 1'b0,
           bv,
           m_pos == 0,
           (m_pos >= 0) || (m_q.size() > 0)};
    check(name, {data_ready, encode_out, bit_valid, frame_start, busy}, exp);
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_clock();
    #1;
    compare_model(name);
  endtask

  task automatic sample();
    if (frame_start) fc = 0;
    if (bit_valid) begin
      fr[fc] = encode_out;
      fc++;
      if (fc == 7) begin
        check("syndrome", {29'd0, fr[0]^fr[1]^fr[2]^fr[3], fr[0]^fr[1]^fr[4]^fr[5],
                           fr[0]^fr[2]^fr[4]^fr[6]}, 32'd0);
        dq.push_back(int'({fr[4], fr[2], fr[1], fr[0]}));
        fc = 0;
      end
    end
  endtask

  task automatic run_until_idle(input bit collect);
    int c;
    c = 0;
    while (busy === 1'b1 && c < 60) begin
      step("drain");
      if (collect) sample();
      c++;
    end
    check("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [6:0] got;
    logic       s_enc, s_bv;
    int         en_cycles, c, idx, fs_last, cyc;
    int         seq[3];

    vecs[0] = '{4'b1011, 7'h33};
    vecs[1] = '{4'h0,    7'h00};
    vecs[2] = '{4'hF,    7'h7F};
    vecs[3] = '{4'h1,    7'h69};
    vecs[4] = '{4'h3,    7'h43};
    vecs[5] = '{4'hA,    7'h5A};
    vecs[6] = '{4'h5,    7'h25};

    rst_n = 1'b0; ena = 1'b0; data_valid = 1'b0; data_in = 4'h0; pg_in = 4'h0;
    fc = 0; fr = '0;
    model_reset();
    #1;
    compare_model("reset_state");
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset_held");
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {31'd0, data_ready}, 32'd1);

    // Table-driven single frames, ena tied high.
    ena = 1'b1;
    foreach (vecs[k]) begin
      data_in = vecs[k].nib; data_valid = 1'b1;
      step("accept");
      check("accepted", {31'd0, m_acc}, 32'd1);
      data_valid = 1'b0;
      for (int s = 0; s < 7; s++) begin
        got[s] = encode_out;
        check("frame_start_slot", {31'd0, frame_start}, {31'd0, s == 0});
        step("send");
      end
      check("gap_level", {30'd0, encode_out, bit_valid}, 32'd0);
      check("codeword", {25'd0, got}, {25'd0, vecs[k].cw});
      step("gap_to_idle");
      check("idle_ready", {30'd0, data_ready, busy}, 32'd2);
    end

    // Parity generator sweep.
    for (int i = 0; i < 16; i++) begin
      pg_in = 4'(i);
      #1;
      check("parity_gen", {25'd0, pg_out}, ref_cw(i));
    end

    // Loopback: continuous valid with 3, A, 5; frames back to back every 8 cycles.
    seq = '{3, 10, 5};
    dq.delete(); fc = 0; idx = 0; fs_last = -1; cyc = 0;
    data_in = 4'(seq[0]); data_valid = 1'b1;
    for (int c2 = 0; c2 < 40; c2++) begin
      step("loopback");
      cyc++;
      if (m_acc) begin
        idx++;
        if (idx < 3) data_in = 4'(seq[idx]);
        else data_valid = 1'b0;
      end
      if (frame_start) begin
        if (fs_last >= 0) check("frame_spacing", cyc - fs_last, 8);
        fs_last = cyc;
      end
      sample();
    end
    check("loopback_count", dq.size(), 3);
    for (int i = 0; i < 3; i++)
      check("loopback_data", (dq.size() > i) ? dq[i] : -1, seq[i]);

    // Pending full: second nibble in SEND, third held until the buffer drains.
    dq.delete(); fc = 0;
    data_in = 4'h9; data_valid = 1'b1;
    step("pend_a"); sample();
    data_valid = 1'b0;
    step("pend_b"); sample();
    step("pend_c"); sample();
    data_in = 4'h6; data_valid = 1'b1;
    step("pend_d"); sample();
    check("ready_low_pending", {31'd0, data_ready}, 32'd0);
    data_in = 4'hC;
    c = 0;
    while (c < 20) begin
      step("pend_wait"); sample();
      c++;
      if (m_acc) break;
    end
    check("third_accepted", {31'd0, m_acc}, 32'd1);
    data_valid = 1'b0;
    run_until_idle(1'b1);
    check("pend_count", dq.size(), 3);
    check("pend_0", (dq.size() > 0) ? dq[0] : -1, 9);
    check("pend_1", (dq.size() > 1) ? dq[1] : -1, 6);
    check("pend_2", (dq.size() > 2) ? dq[2] : -1, 12);

    // ena low for 3 cycles at slot 4.
    data_in = 4'hA; data_valid = 1'b1;
    step("ena_accept");
    data_valid = 1'b0;
    en_cycles = 1;
    repeat (4) begin step("ena_pre"); en_cycles++; end
    s_enc = encode_out; s_bv = bit_valid;
    ena = 1'b0;
    repeat (3) begin
      step("ena_low");
      check("ena_freeze", {30'd0, encode_out, bit_valid}, {30'd0, s_enc, s_bv});
    end
    ena = 1'b1;
    c = 0;
    while (busy === 1'b1 && c < 20) begin step("ena_resume"); en_cycles++; c++; end
    check("ena_frame_len", en_cycles, 9);  // accept edge + 8 frame slots

    // Reset mid-frame at slot 3 with a nibble pending.
    data_in = 4'h7; data_valid = 1'b1;
    step("rst_a");
    data_in = 4'h2;
    step("rst_b");
    data_valid = 1'b0;
    step("rst_c");
    step("rst_d");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async", {data_ready, encode_out, bit_valid, frame_start, busy}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      step("post_reset");
      check("no_residual", {30'd0, encode_out, bit_valid}, 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      ena        = ($urandom_range(0, 3) != 0);
      data_valid = $urandom_range(0, 1);
      data_in    = 4'($urandom);
      step("random");
    end
    data_valid = 1'b0; ena = 1'b1;
    run_until_idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
